// File: rtl/cmp_sweep_checker_if.sv
// Signal bundle between the sweep checker, the comparator under test and the board/harness.
// The checker takes the master side; the comparator and start/status consumer take the slave side.
interface cmp_sweep_checker_if #(
    parameter int WIDTH = 2
);
    logic               start;
    logic [WIDTH-1:0]   stim_a;
    logic [WIDTH-1:0]   stim_b;
    logic               resp_gt;
    logic               resp_eq;
    logic               resp_lt;
    logic               busy;
    logic               done;
    logic               pass;
    logic [2*WIDTH:0]   err_count;
    logic               fail_valid;
    logic [WIDTH-1:0]   fail_a;
    logic [WIDTH-1:0]   fail_b;

    modport master (
        input  start, resp_gt, resp_eq, resp_lt,
        output stim_a, stim_b, busy, done, pass, err_count, fail_valid, fail_a, fail_b
    );

    modport slave (
        output start, resp_gt, resp_eq, resp_lt,
        input  stim_a, stim_b, busy, done, pass, err_count, fail_valid, fail_a, fail_b
    );
endinterface

// File: rtl/cmp_sweep_checker.sv
// Exhaustive sweep engine for a 2-input magnitude comparator: drives every operand pair,
// samples the three compare outputs after a settle window and reports pass/fail and the first failure.
module cmp_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    cmp_sweep_checker_if.master bus
);
    localparam int VW    = 2 * WIDTH;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] settle_cnt;
    logic [VW-1:0]    vec;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [VW:0]      err_q;
    logic             fail_valid_q;
    logic [WIDTH-1:0] fail_a_q;
    logic [WIDTH-1:0] fail_b_q;

    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [2:0]       expected;
    logic [2:0]       observed;
    logic             vec_fail;
    logic             last_vec;
    logic [VW:0]      err_next;

    // Golden one-hot is {A>B, A==B, A<B}; any deviation, including multi-hot or all-zero, is a failure.
    always_comb begin
        cur_a    = vec[VW-1:WIDTH];
        cur_b    = vec[WIDTH-1:0];
        expected = {cur_a > cur_b, cur_a == cur_b, cur_a < cur_b};
        observed = {bus.resp_gt, bus.resp_eq, bus.resp_lt};
        vec_fail = (observed != expected);
        last_vec = &vec;
        err_next = vec_fail ? err_q + (VW+1)'(1) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            vec          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state        <= S_APPLY;
                        settle_cnt   <= '0;
                        vec          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err_q <= err_next;
                    // Only the first failing vector is kept so the report points at the earliest fault.
                    if (vec_fail && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_a_q     <= cur_a;
                        fail_b_q     <= cur_b;
                    end
                    settle_cnt <= '0;
                    if (last_vec) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_next == '0);
                    end else begin
                        state <= S_APPLY;
                        vec   <= vec + VW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stim_a     = cur_a;
    assign bus.stim_b     = cur_b;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_a     = fail_a_q;
    assign bus.fail_b     = fail_b_q;
endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: plays comparators with assorted faults and checks the sweep report
// against a loop-based reference computed from the compare rules.
module tb_cmp_sweep_checker;
    localparam int WIDTH  = 2;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << (2 * WIDTH);
    localparam int SWEEP  = NVEC * (SETTLE + 1);

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    int         active_mode;
    int         mask_gen;
    logic [2:0] fault_mask [NVEC];
    logic [2:0] resp;

    cmp_sweep_checker_if #(.WIDTH(WIDTH)) bus ();

    cmp_sweep_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator under test: mode 0 correct, 1 eq stuck low, 2 gt/lt swapped, 3 all high, 4 random per-vector faults.
    function automatic logic [2:0] model_resp(input int mode, input int a, input int b);
        logic [2:0] golden;
        golden = {a > b, a == b, a < b};
        case (mode)
            1:       return golden & 3'b101;
            2:       return {a < b, a == b, a > b};
            3:       return 3'b111;
            4:       return golden ^ fault_mask[a * (1 << WIDTH) + b];
            default: return golden;
        endcase
    endfunction

    always @(bus.stim_a or bus.stim_b or active_mode or mask_gen) begin
        resp = model_resp(active_mode, int'(bus.stim_a), int'(bus.stim_b));
    end

    assign bus.resp_gt = resp[2];
    assign bus.resp_eq = resp[1];
    assign bus.resp_lt = resp[0];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},   32'(bus.busy),       0);
        checkOutput({tag, "_done"},   32'(bus.done),       0);
        checkOutput({tag, "_pass"},   32'(bus.pass),       0);
        checkOutput({tag, "_err"},    32'(bus.err_count),  0);
        checkOutput({tag, "_fvalid"}, 32'(bus.fail_valid), 0);
        checkOutput({tag, "_stim"},   32'({bus.stim_a, bus.stim_b}), 0);
        checkOutput({tag, "_fail_ab"}, 32'({bus.fail_a, bus.fail_b}), 0);
    endtask

    // Runs one full sweep with the given comparator mode; hold keeps start high until done is seen.
    task automatic applyStimulus(input int mode, input bit hold);
        int errs;
        int first_a;
        int first_b;
        bit have_fail;
        int cycles;
        int a;
        int b;

        if (mode == 4) begin
            for (int i = 0; i < NVEC; i++)
                fault_mask[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            mask_gen++;
        end
        active_mode = mode;

        errs = 0; have_fail = 0; first_a = 0; first_b = 0;
        for (int idx = 0; idx < NVEC; idx++) begin
            a = idx / (1 << WIDTH);
            b = idx % (1 << WIDTH);
            if (model_resp(mode, a, b) != {a > b, a == b, a < b}) begin
                errs++;
                if (!have_fail) begin
                    have_fail = 1; first_a = a; first_b = b;
                end
            end
        end

        bus.start = 1'b1;
        @(posedge clk); #1;
        checkOutput("start_busy",   32'(bus.busy),       1);
        checkOutput("start_done",   32'(bus.done),       0);
        checkOutput("start_stim",   32'({bus.stim_a, bus.stim_b}), 0);
        checkOutput("start_err",    32'(bus.err_count),  0);
        checkOutput("start_fvalid", 32'(bus.fail_valid), 0);
        if (!hold) bus.start = 1'b0;

        cycles = 0;
        while (!bus.done && cycles < 4 * SWEEP) begin
            @(posedge clk); #1;
            cycles++;
            if (!bus.done && !bus.busy) checkOutput("busy_dropped", 32'(bus.busy), 1);
        end
        bus.start = 1'b0;
        checkOutput("sweep_len",  32'(cycles),           32'(SWEEP));
        checkOutput("end_busy",   32'(bus.busy),         0);
        checkOutput("end_pass",   32'(bus.pass),         32'(errs == 0));
        checkOutput("end_err",    32'(bus.err_count),    32'(errs));
        checkOutput("end_fvalid", 32'(bus.fail_valid),   32'(have_fail));
        checkOutput("end_stim",   32'({bus.stim_a, bus.stim_b}), 32'(NVEC - 1));
        if (have_fail) begin
            checkOutput("end_fail_a", 32'(bus.fail_a), 32'(first_a));
            checkOutput("end_fail_b", 32'(bus.fail_b), 32'(first_b));
        end
        @(posedge clk); #1;
        checkOutput("done_held", 32'(bus.done), 1);
    endtask

    initial begin
        int waited;
        tests_run    = 0;
        tests_failed = 0;
        active_mode  = 0;
        mask_gen     = 0;
        for (int i = 0; i < NVEC; i++) fault_mask[i] = 3'b000;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 0);
        applyStimulus(0, 1);
        applyStimulus(3, 1);
        applyStimulus(0, 0);

        // Abort mid-sweep while vector (1,1) is applied.
        active_mode = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waited = 0;
        while ({bus.stim_a, bus.stim_b} != 4'b0101 && waited < 4 * SWEEP) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("reach_11", 32'({bus.stim_a, bus.stim_b}), 32'h5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkAllZero("midrst");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_done", 32'(bus.done), 0);
        checkOutput("idle_busy", 32'(bus.busy), 0);
        applyStimulus(0, 0);

        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 4), bit'($urandom_range(0, 1)));
        end
        applyStimulus(4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Self-checking sweep engine for the 2-input magnitude-comparator labs; it is the response side of the exhaustive comparator stimulus sequence.
- Drives every operand pair into a comparator under test and samples its three outputs after a settle window.
- Checks the outputs against golden compare results, then reports pass/fail, an error count and the first failing vector.
- Sits between the comparator and board LEDs/switches, or inside a simulation harness.

Parameters:
- WIDTH, 2, operand width in bits. Sweep covers 2^(2*WIDTH) vectors.
- SETTLE, 2, cycles each vector is held before sampling. Must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled start request; acted on only in IDLE or DONE.
- stim_a  output  WIDTH  operand A to the comparator (registered).
- stim_b  output  WIDTH  operand B to the comparator (registered).
- resp_gt  input  1  comparator output o1; expected high when A>B.
- resp_eq  input  1  comparator output o2; expected high when A==B.
- resp_lt  input  1  comparator output o3; expected high when A<B.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high (level) once a sweep has completed; held until restart or rst.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  2*WIDTH+1  number of failing vectors; saturation is not needed.
- fail_valid  output  1  high once at least one failing vector has been captured.
- fail_a  output  WIDTH  A operand of the first failing vector.
- fail_b  output  WIDTH  B operand of the first failing vector.

Behaviour:
- Reset: rst=1 at an edge forces state IDLE and clears all outputs to 0, including stim_a, stim_b, busy, done, pass, err_count, fail_valid, fail_a, fail_b and the internal settle counter.
  - rst has priority over start and over any in-flight sweep.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE -> APPLY on start=1. The same edge:
  - loads {stim_a,stim_b}=0 and clears the settle counter;
  - sets busy=1 and done=0;
  - clears err_count, fail_valid, fail_a and fail_b.
- APPLY:
  - Holds the stimulus and increments the settle counter each cycle.
  - After SETTLE cycles in APPLY, transitions to CHECK.
- CHECK (one cycle): samples the response inputs and compares {resp_gt,resp_eq,resp_lt} against the expected one-hot {A>B, A==B, A<B}.
  - Any bit mismatch marks the vector failed, including multi-hot or all-zero responses.
  - A failed vector adds exactly 1 to err_count.
  - If fail_valid=0 on a failure, capture fail_a=stim_a, fail_b=stim_b and set fail_valid=1. Later failures do not overwrite the capture.
  - Not last vector: increment the concatenated {stim_a,stim_b} (A is the MSB half, B the LSB half; B wraps into A), clear the settle counter, go to APPLY.
  - Last vector ({stim_a,stim_b} all ones): go to DONE. Stimulus stays at all ones.
- DONE:
  - busy=0, done=1, and pass=(final err_count==0).
  - start=1 restarts exactly as from IDLE.
- Sweep order: (0,0),(0,1),…,(0,3),(1,0),…,(3,3) for WIDTH=2.
- Timing: vector period is SETTLE+1 cycles.
  - With start sampled at edge k, done rises at edge k + 2^(2*WIDTH)*(SETTLE+1), which is k+48 at the defaults.
- start while busy=1 is ignored.
- The response inputs are only observed in CHECK; glitches during APPLY have no effect.
- Reset mid-sweep aborts the sweep with no partial report. A subsequent start runs a full sweep from (0,0).

Test Plan:
- Correct comparator model, start pulse at edge k -> busy=1 from k, done=1 and busy=0 at k+48, pass=1, err_count=0, fail_valid=0, stim ends at (3,3).
- Model with resp_eq stuck at 0 -> err_count=4, pass=0, fail_valid=1, fail_a=0, fail_b=0.
- Model with gt/lt swapped -> err_count=12, first fail captured as (0,1), pass=0.
- Model driving all three outputs high -> err_count=16; first fail (0,0) is not overwritten by later failures.
- rst asserted while the sweep is on vector (1,1) -> next edge has all outputs 0 and state IDLE; a new start then gives a full 48-cycle sweep with correct counts.
- start held high through the whole sweep has no effect mid-run.
  - start reasserted in DONE after a failing run -> counts and capture are cleared, and the sweep reruns from (0,0).
